universal_shifter: RTL and testbench

Parametrised multi-cycle shift/rotate engine for the datapath. Parallel-loads a WIDTH-bit word, then on a start request shifts it one bit per clock for a requested number of positions, in logical, arithmetic, serial-fill or rotate mode. Completion is signalled by busy/done handshake outputs. A serial output exposes each bit shifted out. The block replaces the fixed 4-bit, single-position shifter in the datapath.

---
 rtl/universal_shifter.sv | 147 ++++++++++++++
 tb/tb_universal_shifter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/universal_shifter.sv
// universal_shifter
// Multi-cycle shift/rotate engine. A WIDTH-bit word is parallel-loaded in
// IDLE; a start request then shifts it one bit per clock for 'amount'
// positions in logical, arithmetic, rotate or serial-fill mode.
// Optional feature macro: ROTATE_EN (when undefined, mode 2'b10 is logical).
module universal_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SER = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             sout_q,  sout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic [1:0]       mode_q,  mode_d;

  // One-position shift of v; dir_l=1 moves toward the MSB. The fill bit
  // depends on the mode captured at start, not on the live inputs.
  function automatic logic [WIDTH-1:0] shift_word(
    input logic [WIDTH-1:0] v,
    input logic             dir_l,
    input logic [1:0]       m,
    input logic             s
  );
    logic fill;
    fill = 1'b0;
    case (m)
      MODE_LOG: fill = 1'b0;
      MODE_ARI: fill = dir_l ? 1'b0 : v[WIDTH-1];
`ifdef ROTATE_EN
      MODE_ROT: fill = dir_l ? v[WIDTH-1] : v[0];
`else
      MODE_ROT: fill = 1'b0;
`endif
      MODE_SER: fill = s;
      default:  fill = 1'b0;
    endcase
    if (dir_l) begin
      return {v[WIDTH-2:0], fill};
    end else begin
      return {fill, v[WIDTH-1:1]};
    end
  endfunction

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          out_d = data;
        end else if (start) begin
          dir_d  = dir;
          mode_d = mode;
          cnt_d  = amount;
          if (amount != {CNT_W{1'b0}}) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        out_d  = shift_word(out_q, dir_q, mode_q, sin);
        sout_d = dir_q ? out_q[WIDTH-1] : out_q[0];
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= {WIDTH{1'b0}};
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign out  = out_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_universal_shifter.sv
// Directed self-checking bench for universal_shifter (WIDTH=8).
module tb_universal_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       load;
  logic       start;
  logic       dir;
  logic [1:0] mode;
  logic [3:0] amount;
  logic       sin;
  logic [7:0] out;
  logic       sout;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  int bcyc;
  int dcyc;

  universal_shifter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .data(data), .load(load), .start(start),
    .dir(dir), .mode(mode), .amount(amount), .sin(sin),
    .out(out), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    data = v; load = 1'b1; tick(); load = 1'b0;
  endtask

  // Start an operation and count busy/done cycles until busy drops (bounded).
  task automatic run_op(input logic d, input logic [1:0] m, input logic [3:0] a,
                        output int bc, output int dc);
    dir = d; mode = m; amount = a; start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      bc++;
      if (done) dc++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; data = 8'h00; load = 1'b0; start = 1'b0;
    dir = 1'b0; mode = 2'b00; amount = 4'd0; sin = 1'b0;
    #12;
    chk("rst_out", out, 8'h00);
    chk("rst_sout", sout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset = 1'b1;
    tick();

    // Logical left by 3.
    do_load(8'hB4);
    chk("load_b4", out, 8'hB4);
    run_op(1'b1, 2'b00, 4'd3, bcyc, dcyc);
    chk("lsl3_out", out, 8'hA0);
    chk("lsl3_sout", sout, 1'b1);
    chk("lsl3_busy_cycles", bcyc, 32'd4);
    chk("lsl3_done_cycles", dcyc, 32'd1);

    // Arithmetic right by 2.
    do_load(8'h96);
    run_op(1'b0, 2'b01, 4'd2, bcyc, dcyc);
    chk("asr2_out", out, 8'hE5);
    chk("asr2_sout", sout, 1'b1);
    chk("asr2_busy_cycles", bcyc, 32'd3);

    // Rotate left by 1, then rotate right by 9.
    do_load(8'h81);
    run_op(1'b1, 2'b10, 4'd1, bcyc, dcyc);
`ifdef ROTATE_EN
    chk("rol1_out", out, 8'h03);
`else
    chk("rol1_out", out, 8'h02);
`endif
    chk("rol1_sout", sout, 1'b1);
    run_op(1'b0, 2'b10, 4'd9, bcyc, dcyc);
`ifdef ROTATE_EN
    chk("ror9_out", out, 8'h81);
    chk("ror9_sout", sout, 1'b1);
`else
    chk("ror9_out", out, 8'h00);
    chk("ror9_sout", sout, 1'b0);
`endif
    chk("ror9_busy_cycles", bcyc, 32'd10);

    // Logical right by WIDTH+1 clears the word.
    do_load(8'hFF);
    run_op(1'b0, 2'b00, 4'd9, bcyc, dcyc);
    chk("lsr9_out", out, 8'h00);

    // Serial right by 4 with sin = 1,0,1,1 on successive shift edges.
    do_load(8'h00);
    dir = 1'b0; mode = 2'b11; amount = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ser_busy_start", busy, 1'b1);
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin = 1'b1; tick();
    sin = 1'b0;
    chk("ser_out", out, 8'hD0);
    chk("ser_done", done, 1'b1);
    tick();
    chk("ser_idle", busy, 1'b0);

    // amount = 0: done and busy in the single cycle after acceptance.
    do_load(8'h5A);
    dir = 1'b1; mode = 2'b00; amount = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("amt0_done", done, 1'b1);
    chk("amt0_busy", busy, 1'b1);
    chk("amt0_out", out, 8'h5A);
    tick();
    chk("amt0_done_low", done, 1'b0);
    chk("amt0_busy_low", busy, 1'b0);

    // load and start together: only the load happens.
    data = 8'h3C; load = 1'b1; start = 1'b1; dir = 1'b1; mode = 2'b00; amount = 4'd2;
    tick();
    load = 1'b0; start = 1'b0;
    chk("ldst_out", out, 8'h3C);
    chk("ldst_busy", busy, 1'b0);
    tick();
    chk("ldst_out2", out, 8'h3C);

    // load/start and control changes during busy are ignored.
    do_load(8'h0F);
    dir = 1'b1; mode = 2'b00; amount = 4'd2; start = 1'b1;
    tick();
    data = 8'hFF; load = 1'b1; dir = 1'b0; mode = 2'b11; amount = 4'd7; sin = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    tick();
    chk("busyign_out", out, 8'h3C);
    chk("busyign_done", done, 1'b1);
    tick();
    chk("busyign_idle", busy, 1'b0);
    chk("busyign_final", out, 8'h3C);
    sin = 1'b0;

    // Asynchronous reset in the middle of a shift.
    do_load(8'hFF);
    dir = 1'b0; mode = 2'b00; amount = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midrst_pre_busy", busy, 1'b1);
    chk("midrst_pre_sout", sout, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out", out, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_sout", sout, 1'b0);
    #2 reset = 1'b1;
    tick();
    chk("midrst_after_busy", busy, 1'b0);
    do_load(8'h77);
    chk("midrst_idle_load", out, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
